// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, per-axis phase encoding and the colour-bar table.
package vga_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} phase_e;

  // Index 0 is the leftmost bar (RGB332).
  localparam logic [7:0][7:0] COLOR_BARS = {
    8'h00, 8'h03, 8'hE0, 8'hE3, 8'h1C, 8'h1F, 8'hFC, 8'hFF
  };

  function automatic logic [7:0] bar_color(input logic [2:0] idx);
    return COLOR_BARS[idx];
  endfunction

endpackage

// File: rtl/vga_sync_out_if.sv
// Pixel request / video output bundle. i_test exists only with VGA_TEST_PATTERN_EN.
interface vga_sync_out_if;
  logic [7:0] i_pixel;
`ifdef VGA_TEST_PATTERN_EN
  logic       i_test;
`endif
  logic       o_req;
  logic       o_frame_start;
  logic [2:0] o_red;
  logic [2:0] o_green;
  logic [1:0] o_blue;
  logic       o_hsync;
  logic       o_vsync;
  logic [9:0] o_hcount;
  logic [9:0] o_vcount;

  modport master (
    input  i_pixel,
    output o_req, o_frame_start, o_red, o_green, o_blue,
           o_hsync, o_vsync, o_hcount, o_vcount
`ifdef VGA_TEST_PATTERN_EN
    , input i_test
`endif
  );

  modport slave (
    output i_pixel,
    input  o_req, o_frame_start, o_red, o_green, o_blue,
           o_hsync, o_vsync, o_hcount, o_vcount
`ifdef VGA_TEST_PATTERN_EN
    , output i_test
`endif
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: position counter plus ACTIVE->FRONT->SYNC->BACK phase FSM.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned ACTIVE_LEN = DEF_H_ACTIVE,
  parameter int unsigned FP_LEN     = DEF_H_FP,
  parameter int unsigned SYNC_LEN   = DEF_H_SYNC,
  parameter int unsigned BP_LEN     = DEF_H_BP,
  parameter int unsigned W          = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  output logic [W-1:0] count,
  output phase_e       phase,
  output logic         wrap
);

  localparam int unsigned TOTAL = ACTIVE_LEN + FP_LEN + SYNC_LEN + BP_LEN;
  localparam logic [W-1:0] A_END = W'(ACTIVE_LEN - 1);
  localparam logic [W-1:0] F_END = W'(ACTIVE_LEN + FP_LEN - 1);
  localparam logic [W-1:0] S_END = W'(ACTIVE_LEN + FP_LEN + SYNC_LEN - 1);
  localparam logic [W-1:0] LAST  = W'(TOTAL - 1);

  assign wrap = tick && (count == LAST);

  // Phase advances on the last count of the current phase, so phase always
  // describes the value held in count.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      phase <= ACTIVE;
    end else if (tick) begin
      count <= wrap ? '0 : count + 1'b1;
      unique case (phase)
        ACTIVE: if (count == A_END) phase <= FRONT;
        FRONT:  if (count == F_END) phase <= SYNC;
        SYNC:   if (count == S_END) phase <= BACK;
        BACK:   if (count == LAST)  phase <= ACTIVE;
      endcase
    end
  end

endmodule

// File: rtl/vga_sync_out.sv
// VGA timing generator with 2-cycle colour/sync pipeline.
// Optional colour-bar generator: define VGA_TEST_PATTERN_EN.
module vga_sync_out
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input logic            clk,
  input logic            rst,
  vga_sync_out_if.master bus
);

  localparam int unsigned CW = 10;

  logic [CW-1:0] h_count, v_count;
  phase_e        h_phase, v_phase;
  logic          h_wrap, v_wrap;

  vga_axis_counter #(
    .ACTIVE_LEN(H_ACTIVE), .FP_LEN(H_FP), .SYNC_LEN(H_SYNC), .BP_LEN(H_BP), .W(CW)
  ) u_h_axis (
    .clk(clk), .rst(rst), .tick(1'b1),
    .count(h_count), .phase(h_phase), .wrap(h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE_LEN(V_ACTIVE), .FP_LEN(V_FP), .SYNC_LEN(V_SYNC), .BP_LEN(V_BP), .W(CW)
  ) u_v_axis (
    .clk(clk), .rst(rst), .tick(h_wrap),
    .count(v_count), .phase(v_phase), .wrap(v_wrap)
  );

  // Set after a frame wrap or reset: the next position is h=0, v=0.
  logic fs_q;
  always_ff @(posedge clk) begin
    if (rst) fs_q <= 1'b1;
    else     fs_q <= v_wrap;
  end

  logic vis;
  assign vis = !rst && (h_phase == ACTIVE) && (v_phase == ACTIVE);

  assign bus.o_req         = vis;
  assign bus.o_frame_start = fs_q && !rst;
  assign bus.o_hcount      = h_count;
  assign bus.o_vcount      = v_count;

  // Stage 1: position attributes wait one cycle for the frame-buffer read.
  logic vis_d, hs_n_d, vs_n_d;
`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BAR_W = H_ACTIVE / 8;
  logic       test_d;
  logic [2:0] bar_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      vis_d  <= 1'b0;
      hs_n_d <= 1'b1;
      vs_n_d <= 1'b1;
`ifdef VGA_TEST_PATTERN_EN
      test_d <= 1'b0;
      bar_d  <= '0;
`endif
    end else begin
      vis_d  <= vis;
      hs_n_d <= (h_phase != SYNC);
      vs_n_d <= (v_phase != SYNC);
`ifdef VGA_TEST_PATTERN_EN
      test_d <= bus.i_test;
      bar_d  <= 3'(int'(h_count) / BAR_W);
`endif
    end
  end

  logic [7:0] pix_src;
`ifdef VGA_TEST_PATTERN_EN
  assign pix_src = test_d ? bar_color(bar_d) : bus.i_pixel;
`else
  assign pix_src = bus.i_pixel;
`endif

  // Stage 2: registered colour and sync, aligned to the same position.
  logic [7:0] rgb_q;
  logic       hs_q, vs_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else begin
      rgb_q <= vis_d ? pix_src : 8'h00;
      hs_q  <= hs_n_d;
      vs_q  <= vs_n_d;
    end
  end

  assign bus.o_red   = rgb_q[7:5];
  assign bus.o_green = rgb_q[4:2];
  assign bus.o_blue  = rgb_q[1:0];
  assign bus.o_hsync = hs_q;
  assign bus.o_vsync = vs_q;

endmodule

// File: tb/tb_vga_sync_out.sv
// Directed bench: default-timing DUT for line/pixel/reset checks, small-timing DUT for frame checks.
module tb_vga_sync_out;
  import vga_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst_s;
  vga_sync_out_if bus ();
  vga_sync_out_if sbus ();

  vga_sync_out dut (.clk(clk), .rst(rst), .bus(bus.master));

  // 24 clocks per line, 15 lines per frame -> 360-cycle frame.
  vga_sync_out #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut_s (.clk(clk), .rst(rst_s), .bus(sbus.master));

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  int req_err = 0, hs_err = 0, vs_err = 0, blank_err = 0, fs_cnt = 0;

  initial begin
    logic [7:0] rgb, rgb_s;
    int p;
    logic hs_exp, req_exp;

    rst = 1'b1; rst_s = 1'b1;
    bus.i_pixel = 8'h00; sbus.i_pixel = 8'hFF;
`ifdef VGA_TEST_PATTERN_EN
    bus.i_test = 1'b0; sbus.i_test = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req",   int'(bus.o_req), 0);
    chk("rst_fs",    int'(bus.o_frame_start), 0);
    chk("rst_rgb",   int'({bus.o_red, bus.o_green, bus.o_blue}), 0);
    chk("rst_hsync", int'(bus.o_hsync), 1);
    chk("rst_vsync", int'(bus.o_vsync), 1);
    chk("rst_hcnt",  int'(bus.o_hcount), 0);

    @(posedge clk); #1;
    rst = 1'b0; rst_s = 1'b0;

    for (int cyc = 0; cyc <= 3100; cyc++) begin
      if (cyc < 800)
        bus.i_pixel = (cyc == 6) ? 8'hE0 : (cyc == 10) ? 8'h1C : 8'h00;
      else
        bus.i_pixel = 8'hFF;
`ifdef VGA_TEST_PATTERN_EN
      if (cyc >= 2501) begin
        bus.i_pixel = 8'h55;
        bus.i_test  = 1'b1;
      end
`endif
      rst = (cyc == 2500);

      @(negedge clk);
      rgb   = {bus.o_red, bus.o_green, bus.o_blue};
      rgb_s = {sbus.o_red, sbus.o_green, sbus.o_blue};

      if (cyc < 2500) begin
        req_exp = (cyc % 800) < 640;
        if (bus.o_req !== req_exp) req_err++;
        if (cyc < 2) hs_exp = 1'b1;
        else begin
          p = (cyc - 2) % 800;
          hs_exp = !(p >= 656 && p < 752);
        end
        if (bus.o_hsync !== hs_exp) hs_err++;
        if (bus.o_vsync !== 1'b1) vs_err++;
        if (cyc >= 1442 && cyc <= 1601 && rgb != 8'h00) blank_err++;
      end
      if (cyc < 720 && sbus.o_frame_start === 1'b1) fs_cnt++;

      case (cyc)
        0: begin
          chk("c0_fs", int'(bus.o_frame_start), 1);
          chk("c0_req", int'(bus.o_req), 1);
          chk("c0_h", int'(bus.o_hcount), 0);
          chk("c0_v", int'(bus.o_vcount), 0);
        end
        1:    chk("c1_fs", int'(bus.o_frame_start), 0);
        7: begin
          chk("pix_red", int'(bus.o_red), 7);
          chk("pix_green", int'(bus.o_green), 0);
          chk("pix_blue", int'(bus.o_blue), 0);
        end
        8:    chk("pix_next", int'(rgb), 8'h00);
        11:   chk("pix_1c", int'(rgb), 8'h1C);
        639:  chk("req_639", int'(bus.o_req), 1);
        640:  chk("req_640", int'(bus.o_req), 0);
        657:  chk("hs_657", int'(bus.o_hsync), 1);
        658:  chk("hs_658", int'(bus.o_hsync), 0);
        753:  chk("hs_753", int'(bus.o_hsync), 0);
        754:  chk("hs_754", int'(bus.o_hsync), 1);
        799:  chk("h_799", int'(bus.o_hcount), 799);
        800: begin
          chk("h_wrap", int'(bus.o_hcount), 0);
          chk("v_inc", int'(bus.o_vcount), 1);
        end
        802:  chk("l1_pix0", int'(rgb), 8'hFF);
        1441: chk("l1_pix639", int'(rgb), 8'hFF);
        1442: chk("l1_blank640", int'(rgb), 8'h00);
        1602: chk("l2_pix0", int'(rgb), 8'hFF);
        2500: begin
          chk("mrst_req", int'(bus.o_req), 0);
          chk("mrst_fs", int'(bus.o_frame_start), 0);
        end
        2501: begin
          chk("mrst_h", int'(bus.o_hcount), 0);
          chk("mrst_v", int'(bus.o_vcount), 0);
          chk("mrst_fs1", int'(bus.o_frame_start), 1);
          chk("mrst_req1", int'(bus.o_req), 1);
          chk("mrst_rgb0", int'(rgb), 8'h00);
          chk("mrst_hs", int'(bus.o_hsync), 1);
        end
        2502: begin
          chk("mrst_rgb1", int'(rgb), 8'h00);
          chk("mrst_fs2", int'(bus.o_frame_start), 0);
        end
        2503: chk("mrst_pix0", int'(rgb), 8'hFF);
`ifdef VGA_TEST_PATTERN_EN
        2583: chk("bar_80", int'(rgb), 8'hFC);
        2663: chk("bar_160", int'(rgb), 8'h1F);
        3063: chk("bar_560", int'(rgb), 8'h00);
`else
        3063: chk("pix_560", int'(rgb), 8'hFF);
`endif
        default: ;
      endcase

      case (cyc)
        0:   chk("s_fs_0", int'(sbus.o_frame_start), 1);
        2:   chk("s_pix0", int'(rgb_s), 8'hFF);
        17:  chk("s_pix15", int'(rgb_s), 8'hFF);
        18:  chk("s_blank16", int'(rgb_s), 8'h00);
        19:  chk("s_hs_19", int'(sbus.o_hsync), 1);
        20:  chk("s_hs_20", int'(sbus.o_hsync), 0);
        23: begin
          chk("s_hs_23", int'(sbus.o_hsync), 0);
          chk("s_h_23", int'(sbus.o_hcount), 23);
        end
        24: begin
          chk("s_hs_24", int'(sbus.o_hsync), 1);
          chk("s_h_24", int'(sbus.o_hcount), 0);
        end
        194: chk("s_vblank", int'(rgb_s), 8'h00);
        241: chk("s_vs_241", int'(sbus.o_vsync), 1);
        242: chk("s_vs_242", int'(sbus.o_vsync), 0);
        289: chk("s_vs_289", int'(sbus.o_vsync), 0);
        290: chk("s_vs_290", int'(sbus.o_vsync), 1);
        359: begin
          chk("s_fs_359", int'(sbus.o_frame_start), 0);
          chk("s_v_359", int'(sbus.o_vcount), 14);
        end
        360: begin
          chk("s_fs_360", int'(sbus.o_frame_start), 1);
          chk("s_v_360", int'(sbus.o_vcount), 0);
        end
        361: chk("s_fs_361", int'(sbus.o_frame_start), 0);
        default: ;
      endcase

      @(posedge clk); #1;
    end

    chk("req_window", req_err, 0);
    chk("hsync_line", hs_err, 0);
    chk("vsync_idle", vs_err, 0);
    chk("hblank_rgb", blank_err, 0);
    chk("s_fs_count", fs_cnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
